lpddr4_port_arbiter: RTL and testbench
======================================

# lpddr4_port_arbiter

Round-robin arbiter that shares the single user command port of the LPDDR4 EMIF (x32, one channel) among NUM_REQ fabric requesters. It registers the winning command toward the EMIF and records the requester ID of every read in an in-order tag FIFO. Returning read data is steered back to the requester that issued it. It sits between the traffic generators/user masters and the EMIF user interface, inside the EMIF user clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, command address width
- DATA_W, 256, beat width (one command = one beat)
- TAG_DEPTH, 16, read-tag FIFO depth (power of 2, max reads in flight)

Ports:
- emif_usr_clk  in  1  EMIF user clock; all logic on rising edge
- emif_usr_reset_n  in  1  asynchronous active-low reset
- emif_cal_success  in  1  calibration done; no command issued while 0
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester accept
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- mem_valid  out  1  command valid to EMIF
- mem_ready  in  1  EMIF accept
- mem_write, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  registered command fields
- mem_rvalid  in  1  read data valid; not stallable
- mem_rdata  in  DATA_W  read data; returns in command order
- rsp_valid  out  NUM_REQ  one-hot read response valid; requesters always accept
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- rd_outstanding  out  $clog2(TAG_DEPTH)+1  reads in flight
- rsp_err  out  1  sticky: mem_rvalid arrived with tag FIFO empty

## Operation
- Output slot: one register stage (mem_valid + fields). The slot is free when mem_valid=0 or (mem_valid & mem_ready).
- Arbitration: evaluated every cycle the slot is free and emif_cal_success=1. Eligible = req_valid[i] & !(req_write[i]==0 & tag FIFO full). Winner = first eligible index at or after rr_ptr, scanning upward with wrap.
- Grant: req_ready[winner]=1 for that cycle only (combinational from the current inputs). All other req_ready are 0. The command is accepted on that edge.
  - On accept: the slot loads the winner's fields and rr_ptr is set to winner+1 mod NUM_REQ.
  - If the command is a read, the winner ID is pushed into the tag FIFO.
- No eligible requester: the slot empties if drained and rr_ptr holds.
- Response path: on mem_rvalid, pop the tag FIFO head. Next cycle, rsp_valid[head]=1 and rsp_rdata=mem_rdata (registered).
- rd_outstanding: +1 on read accept, -1 on mem_rvalid, unchanged when both occur in the same cycle. It never exceeds TAG_DEPTH.
- Error: mem_rvalid with FIFO empty sets rsp_err, produces no rsp_valid, and leaves the counter unchanged (no underflow). rsp_err clears only on reset.
- emif_cal_success deasserting mid-operation: no new grants. A command already held in the slot stays valid until mem_ready. Responses keep flowing.

## Timing
- Reset values: mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rd_outstanding=0, rsp_err=0, rr_ptr=0, FIFO empty.
- Request to mem_valid: 1 cycle (accept edge). Back-to-back accepts are possible every cycle while mem_ready=1.
- mem_valid/fields are stable while mem_valid & !mem_ready (AXI-style hold).
- mem_rvalid to rsp_valid: 1 cycle.
- Tag FIFO full case: a read push and an rvalid pop in the same cycle are allowed. Fullness for eligibility uses the registered count, not the simultaneous pop.

## Test plan
- Reset/calibration: hold emif_cal_success=0 with all req_valid=1 -> req_ready=0 and mem_valid=0. Raise emif_cal_success -> requester 0 granted first, mem_valid one cycle later.
- Fairness: all 4 requesters issue continuous writes with mem_ready=1 -> grant order 0,1,2,3,0,… and mem_addr matches each requester's address per beat.
- Backpressure: mem_ready=0 for 5 cycles with a command in the slot -> fields are unchanged, no req_ready pulses. When released, the next grant goes to the next index in rotation.
- Read steering: reads from req 2, 0, 3 in that order; return three mem_rvalid beats A, B, C -> rsp_valid one-hot 2, 0, 3 carrying A, B, C, each one cycle after its rvalid.
- Full FIFO: issue 16 reads with no returns -> rd_outstanding=16 and further reads are blocked while writes are still granted. One rvalid -> exactly one more read is accepted.
- Error: mem_rvalid with nothing outstanding -> rsp_err=1 (sticky), no rsp_valid, rd_outstanding stays 0.

Source files
------------

// File: rtl/lpddr4_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// lpddr4_port_arbiter_if
//   Bundles the three buses around the LPDDR4 port arbiter:
//     - requester command side (req_valid/req_ready/req_write/req_addr/req_wdata,
//       one lane per requester, packed)
//     - EMIF command side (mem_valid/mem_ready/mem_write/mem_addr/mem_wdata)
//     - read return side (mem_rvalid/mem_rdata in, rsp_valid/rsp_rdata out)
//   modport slave  : the arbiter's view
//   modport master : the surrounding fabric / EMIF view
// ---------------------------------------------------------------------------
interface lpddr4_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;

  logic                      mem_valid;
  logic                      mem_ready;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;

  logic                      mem_rvalid;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready,
    output mem_valid, mem_write, mem_addr, mem_wdata,
    output rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready,
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    input  rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/lpddr4_port_arbiter.sv
// ---------------------------------------------------------------------------
// lpddr4_port_arbiter
//   Round-robin arbiter sharing the single LPDDR4 EMIF user command port among
//   NUM_REQ requesters. The winning command is registered into a one-deep
//   output slot; every accepted read pushes its requester ID into an in-order
//   tag FIFO, and returning read beats are steered back using the FIFO head.
//
// Ports
//   emif_usr_clk      : EMIF user clock, all logic on the rising edge
//   emif_usr_reset_n  : asynchronous active-low reset
//   emif_cal_success  : calibration done; no grants while low
//   bus (slave)       : requester, EMIF command and read-return buses
//   rd_outstanding    : number of reads accepted but not yet returned
//   rsp_err           : sticky, read data arrived with no read outstanding
// ---------------------------------------------------------------------------
module lpddr4_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int TAG_DEPTH = 16
) (
  input  logic                       emif_usr_clk,
  input  logic                       emif_usr_reset_n,
  input  logic                       emif_cal_success,
  lpddr4_port_arbiter_if.slave       bus,
  output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
  output logic                       rsp_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-requester views of the packed input buses
  logic [ADDR_W-1:0] req_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] req_wdata_arr [NUM_REQ];

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               mem_valid_q, mem_valid_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [ID_W-1:0]    tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    tag_head;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               tag_full, tag_empty;
  logic               slot_free, arb_en;
  logic [NUM_REQ-1:0] eligible, grant;
  logic               grant_any;
  logic [ID_W-1:0]    winner;
  logic               tag_push, tag_pop;

  // Fullness uses the registered count: a pop in the same cycle does not
  // make room for a read until the following cycle.
  assign tag_full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (cnt_q == '0);
  assign slot_free = !mem_valid_q || bus.mem_ready;
  assign arb_en    = slot_free && emif_cal_success;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign req_wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
      assign eligible[gi]      = bus.req_valid[gi] && !(!bus.req_write[gi] && tag_full);
      assign grant[gi]         = grant_any && (winner == ID_W'(gi));
    end
  endgenerate

  // First eligible index at or after rr_ptr, with wrap. Scanning from the
  // farthest offset down lets the nearest candidate overwrite the result.
  always_comb begin
    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] cand;
    grant_any = 1'b0;
    winner    = '0;
    idx_sum   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (idx_sum >= (ID_W + 1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (ID_W + 1)'(NUM_REQ);
      end
      cand = idx_sum[ID_W-1:0];
      if (arb_en && eligible[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
  end

  assign bus.req_ready = grant;

  assign tag_push = grant_any && !bus.req_write[winner];
  assign tag_pop  = bus.mem_rvalid && !tag_empty;
  assign tag_head = tag_mem[rd_ptr_q];

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    // Output slot: load on grant, otherwise empty once the EMIF takes it.
    if (grant_any) begin
      mem_valid_d = 1'b1;
      mem_write_d = bus.req_write[winner];
      mem_addr_d  = req_addr_arr[winner];
      mem_wdata_d = req_wdata_arr[winner];
      rr_ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    end else if (bus.mem_ready) begin
      mem_valid_d = 1'b0;
    end

    if (tag_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (tag_pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      rsp_valid_d = NUM_REQ'(1) << tag_head;
      rsp_rdata_d = bus.mem_rdata;
    end

    case ({tag_push, tag_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (bus.mem_rvalid && tag_empty) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      rr_ptr_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Tag storage needs no reset: entries are only read behind the count.
  always_ff @(posedge emif_usr_clk) begin
    if (tag_push) begin
      tag_mem[wr_ptr_q] <= winner;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign rd_outstanding = cnt_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_lpddr4_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lpddr4_port_arbiter
//   Randomized requester/EMIF traffic around lpddr4_port_arbiter. A reference
//   model (round-robin rule, list of outstanding read owners, expected command
//   and response queues) runs on the falling edge; monitors pop the expected
//   queues whenever the DUT presents a command or a response.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lpddr4_port_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TD = 16;

  typedef struct {
    bit             w;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
  } cmd_t;

  typedef struct {
    int             id;
    logic [DW-1:0]  d;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic cal;
  logic [$clog2(TD):0] rd_outstanding;
  logic rsp_err;

  lpddr4_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  lpddr4_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .emif_usr_clk     (clk),
    .emif_usr_reset_n (rst_n),
    .emif_cal_success (cal),
    .bus              (bus.slave),
    .rd_outstanding   (rd_outstanding),
    .rsp_err          (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int      rr_m;
  bit      slot_m;
  bit      err_m;
  int      tag_q[$];
  cmd_t    cmd_q[$];
  rsp_t    rsp_q[$];

  int      tests;
  int      fails;
  bit      run;
  logic [NR-1:0] gnt_seen;

  // Stimulus knobs (percent)
  int      p_valid, p_write, p_ready, p_rvalid;
  bit      force_rv;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int wd = 0; wd < DW / 32; wd++) v[wd*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_cmd(input int i);
    logic [AW-1:0] a;
    bus.req_valid[i] = ($urandom_range(99) < p_valid);
    bus.req_write[i] = ($urandom_range(99) < p_write);
    a = {8'(i), 24'($urandom)};
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = rand_data();
  endtask

  // One clock of stimulus, applied just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (!bus.req_valid[i] || gnt_seen[i]) new_cmd(i);
    end
    bus.mem_ready  = ($urandom_range(99) < p_ready);
    bus.mem_rvalid = force_rv || (tag_q.size() > 0 && $urandom_range(99) < p_rvalid);
    bus.mem_rdata  = rand_data();
  endtask

  // Monitors + model, on the falling edge while inputs are stable.
  cmd_t           c;
  rsp_t           r;
  logic [NR-1:0]  exp_g;
  int             win;
  bit             free_m;

  always @(negedge clk) begin
    if (rst_n && run) begin
      // Response monitor: every expected response shows exactly one cycle
      // after its read beat.
      if (bus.rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, '0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_onehot", bus.rsp_valid, NR'(1) << r.id);
          chk("rsp_rdata", bus.rsp_rdata, r.d);
          $display("[TB] rsp  req=%0d data=%h", r.id, bus.rsp_rdata[31:0]);
        end
      end else if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("rsp_missing", bus.rsp_valid, NR'(1) << r.id);
      end

      // Command monitor: slot contents must match the expected command for
      // every cycle it is held, and it retires on mem_ready.
      chk("mem_valid", bus.mem_valid, slot_m);
      if (slot_m && cmd_q.size() > 0) begin
        c = cmd_q[0];
        chk("mem_write", bus.mem_write, c.w);
        chk("mem_addr", bus.mem_addr, c.a);
        chk("mem_wdata", bus.mem_wdata, c.d);
        if (bus.mem_ready) begin
          void'(cmd_q.pop_front());
          $display("[TB] cmd  %s addr=%h data=%h", c.w ? "WR" : "RD", c.a, c.d[31:0]);
        end
      end

      chk("rd_outstanding", rd_outstanding, tag_q.size());
      chk("rsp_err", rsp_err, err_m);

      // Expected grant: nearest eligible requester at or after the pointer.
      exp_g  = '0;
      win    = -1;
      free_m = !slot_m || bus.mem_ready;
      if (free_m && cal) begin
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (rr_m + k) % NR;
          if (win < 0 && bus.req_valid[idx] &&
              !(!bus.req_write[idx] && tag_q.size() >= TD)) win = idx;
        end
      end
      if (win >= 0) exp_g[win] = 1'b1;
      chk("req_ready", bus.req_ready, exp_g);
      gnt_seen = bus.req_ready;

      // Advance the model to the state after the coming edge.
      if (bus.mem_rvalid) begin
        if (tag_q.size() > 0) begin
          r.id = tag_q.pop_front();
          r.d  = bus.mem_rdata;
          rsp_q.push_back(r);
        end else begin
          err_m = 1'b1;
        end
      end
      if (win >= 0) begin
        c.w = bus.req_write[win];
        c.a = bus.req_addr[win*AW +: AW];
        c.d = bus.req_wdata[win*DW +: DW];
        cmd_q.push_back(c);
        if (!c.w) tag_q.push_back(win);
        rr_m   = (win + 1) % NR;
        slot_m = 1'b1;
      end else if (bus.mem_ready) begin
        slot_m = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    tests = 0; fails = 0; run = 1'b0;
    rr_m = 0; slot_m = 1'b0; err_m = 1'b0; gnt_seen = '0;
    rst_n = 1'b0; cal = 1'b0; force_rv = 1'b0;
    p_valid = 100; p_write = 100; p_ready = 100; p_rvalid = 0;
    bus.req_valid = '1; bus.req_write = '1;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < NR; i++) new_cmd(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", bus.mem_valid, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_rd_outstanding", rd_outstanding, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;

    // Calibration pending: all requesting, nothing granted. A stray read beat
    // with nothing outstanding raises the sticky error.
    for (int n = 0; n < 6; n++) begin
      force_rv = (n == 2);
      step();
    end
    force_rv = 1'b0;

    // Calibration done: continuous writes rotate 0,1,2,3,...
    cal = 1'b1;
    for (int n = 0; n < 20; n++) step();

    // Backpressure: slot held for 5 cycles, then released.
    p_ready = 0;
    for (int n = 0; n < 5; n++) step();
    p_ready = 100;
    for (int n = 0; n < 6; n++) step();

    // Fill the tag FIFO with reads and no returns; then mixed traffic where
    // only writes can win; then one return frees exactly one slot.
    p_write = 0;
    for (int n = 0; n < 30; n++) step();
    p_write = 50;
    for (int n = 0; n < 10; n++) step();
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    for (int n = 0; n < 5; n++) step();

    // Randomized traffic.
    p_valid = 70; p_write = 50; p_ready = 75; p_rvalid = 40;
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 150) cal = 1'b0;
      if (n % 300 == 170) cal = 1'b1;
      step();
    end

    // Drain everything.
    cal = 1'b1; p_valid = 0; p_ready = 100; p_rvalid = 100;
    budget = 0;
    while ((tag_q.size() != 0 || bus.req_valid != '0 || slot_m) && budget < 500) begin
      step();
      budget++;
    end
    chk("drain_tags_left", tag_q.size(), 0);
    p_rvalid = 0;
    repeat (3) step();
    chk("cmd_q_left", cmd_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    chk("final_rsp_err", rsp_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
